// File: rtl/fetch_imem_responder_pkg.sv
// Shared definitions for the fetch instruction-memory responder: FSM encoding,
// default geometry/latency and the latency counter width.
package fetch_imem_responder_pkg;

    localparam int DEFAULT_DEPTH   = 256;
    localparam int DEFAULT_LATENCY = 2;
    localparam int CNT_W           = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/fetch_imem_responder_imem_array.sv
// Instruction storage: synchronous write, combinational read. A write and a read
// of the same word in one cycle return the old contents (no forwarding).
module imem_array #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 32,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  ridx,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: storage arrays carry no reset; program contents survive rst.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/fetch_imem_responder.sv
// Fetch-side instruction memory responder: one request at a time, fixed LATENCY
// to a single-cycle ack. Optional misalignment reporting under IMEM_ALIGN_CHECK_EN.
module fetch_imem_responder
    import fetch_imem_responder_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              err,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    localparam int             IDX_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              accept, capture;
    logic [IDX_W-1:0]  req_idx, lat_idx, rd_idx, wr_idx;
    logic [DATA_W-1:0] arr_rdata, resp_data, rdata_q;
    logic              unused_addr;

    assign req_idx = addr[IDX_W+1:2];
    assign wr_idx  = wr_addr[IDX_W+1:2];
    // With LATENCY=1 the capture happens on the acceptance edge, before lat_idx is loaded.
    assign rd_idx  = (state == ST_IDLE) ? req_idx : lat_idx;

    imem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (wr_en),
        .widx  (wr_idx),
        .wdata (wr_data),
        .ridx  (rd_idx),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            lat_idx <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                lat_idx <= req_idx;
            end
            if (capture) begin
                rdata_q <= resp_data;
            end
        end
    end

    // NOTE: every combinational output is defaulted first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        capture   = 1'b0;
        ack       = 1'b0;
        busy      = 1'b1;
        unique case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (req) begin
                    accept  = 1'b1;
                    cnt_nxt = CNT_LOAD;
                    if (CNT_LOAD == '0) begin
                        state_nxt = ST_RESP;
                        capture   = 1'b1;
                    end else begin
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = ST_RESP;
                    capture   = 1'b1;
                end
            end
            ST_RESP: begin
                ack       = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign rdata = rdata_q;

`ifdef IMEM_ALIGN_CHECK_EN
    logic req_mis, lat_mis, rd_mis, err_q;

    assign req_mis   = |addr[1:0];
    assign rd_mis    = (state == ST_IDLE) ? req_mis : lat_mis;
    assign resp_data = rd_mis ? '0 : arr_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_mis <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                lat_mis <= req_mis;
            end
            if (capture) begin
                err_q <= rd_mis;
            end
        end
    end

    assign err         = err_q;
    assign unused_addr = ^{addr[ADDR_W-1:IDX_W+2], wr_addr[ADDR_W-1:IDX_W+2], wr_addr[1:0]};
`else
    assign resp_data   = arr_rdata;
    assign err         = 1'b0;
    assign unused_addr = ^{addr[ADDR_W-1:IDX_W+2], addr[1:0],
                           wr_addr[ADDR_W-1:IDX_W+2], wr_addr[1:0]};
`endif

endmodule

// File: doc/fetch_imem_responder.md
# fetch_imem_responder

Instruction-memory responder for the fetch stage. It accepts one word-fetch request at a time from the fetch unit's PC-driven requester. After a fixed, parameterised access latency it returns the instruction word with a single-cycle acknowledge. A side write port preloads program contents before and during simulation.

## Interface
Parameters:
- `ADDR_W`, 32: byte-address width from fetch.
- `DATA_W`, 32: instruction word width.
- `DEPTH`, 256: words in the array; power of two, ≥ 4.
- `LATENCY`, 2: cycles from acceptance to `ack`; 1 to 15.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `req`, in, 1: fetch request. The requester holds `req` and `addr` stable until `ack`.
- `addr`, in, `ADDR_W`: byte address of the instruction.
- `ack`, out, 1: response valid, exactly one cycle per accepted request.
- `rdata`, out, `DATA_W`: instruction word. Valid when `ack`=1; held until the next `ack`.
- `busy`, out, 1: a request is in flight.
- `err`, out, 1: misaligned-address response. Qualified by `ack`.
- `wr_en`, in, 1: preload write strobe.
- `wr_addr`, in, `ADDR_W`: preload byte address.
- `wr_data`, in, `DATA_W`: preload word.

## Operation
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - If `req`=1, latch `addr` and load the counter with `LATENCY-1`.
  - Go to RESP if the loaded value is 0, else go to WAIT.
- WAIT: decrement the counter; go to RESP on the cycle it reaches 0.
- RESP:
  - Drive `ack`=1 and `rdata`=array[latched index].
  - Return to IDLE.
  - `req` is ignored in this cycle.
- Word index is `addr[log2(DEPTH)+1:2]`. Upper bits are ignored, so addresses wrap modulo `DEPTH*4`.
- `busy`=1 in WAIT and RESP, 0 in IDLE.
- `req` seen while not in IDLE has no effect. No queuing.
- Write port:
  - Active in every state.
  - Writes array[`wr_addr` word index] at the edge.
  - A write to the word being read in the RESP-entry cycle is not visible: `rdata` returns the old value. It is visible in the next request.
- Array contents are not cleared by `rst`.

## Timing
- Reset values: state IDLE, `ack`=0, `rdata`=0, `busy`=0, `err`=0, counter 0.
- Acceptance edge is T, with `req`=1 in IDLE.
  - `busy` rises in cycle T+1.
  - `ack` is high in cycle T+`LATENCY` only.
- Throughput is one request per `LATENCY`+1 cycles when `req` is held continuously.
- Reset mid-operation (WAIT or RESP):
  - Return to IDLE next cycle.
  - No `ack` is issued for the aborted request.
  - `rdata` is cleared to 0.
- `rst` and `req` in the same cycle: `rst` wins; the request is not accepted.

## Configuration
- `IMEM_ALIGN_CHECK_EN` defined:
  - A request with `addr[1:0]`≠0 completes with the same latency.
  - The response is `ack`=1, `err`=1, `rdata`=0.
  - `err` is 0 on aligned responses.
- `IMEM_ALIGN_CHECK_EN` undefined:
  - `addr[1:0]` is ignored.
  - `err` is tied to 0.
  - The latch and compare logic is absent.

## Structure
- Shared package holds:
  - the FSM state encoding (IDLE=0, WAIT=1, RESP=2, 2 bits);
  - default `DEPTH` and `LATENCY` constants;
  - the counter width constant (4 bits).
- One sub-module, `imem_array`:
  - `DEPTH`×`DATA_W`;
  - synchronous write, combinational read;
  - write-before-read not forwarded.

## Test plan
- Reset mid-stream:
  - Stimulus: reset, then preload word 3 = 0x00A00093 via the write port. `req` with `addr`=0x0C, `LATENCY`=2.
  - Required: `ack` exactly two cycles after acceptance with `rdata`=0x00A00093 and `busy` high for two cycles. Assert `rst` during WAIT of a second request: no `ack`, `rdata`=0.
- `LATENCY`=1 with `req` held continuously:
  - Stimulus: addresses 0x0, 0x4, 0x8.
  - Required: an `ack` every second cycle; the data sequence matches the preloaded words 0, 1, 2.
- Wrap-around:
  - Stimulus: `DEPTH`=256, `addr`=0x400.
  - Required: returns word 0.
- Write/read collision:
  - Stimulus: write word 5 = 0xDEADBEEF in the RESP-entry cycle of a read of word 5 (previously 0x11111111).
  - Required: `rdata`=0x11111111; the next read returns 0xDEADBEEF.
- Misaligned access:
  - Stimulus: `addr`=0x06.
  - Required with `IMEM_ALIGN_CHECK_EN`: `ack`=1, `err`=1, `rdata`=0.
  - Required without it: `err`=0, `rdata`=word 1.
- Request during busy:
  - Stimulus: drop `req` during WAIT and pulse a new `addr`.
  - Required: the original request completes with the originally latched address; exactly one `ack`.
